ad_trigger_capture: RTL and testbench

- Oscilloscope-style capture stage directly downstream of the AD9226 driver.
- Consumes the offset-corrected signed 12-bit sample stream and detects a level/edge trigger.
- Stores a window of DEPTH samples, PRE_DEPTH of them before the trigger, in a circular RAM.
- Plays the window back oldest-first through a simple read handshake for UART/display logic.

---
 rtl/ad_capture_pkg.sv | 26 ++
 rtl/ad_capture_ram.sv | 29 ++
 rtl/ad_trigger_capture.sv | 180 ++++++++++++++++++
 tb/tb_ad_trigger_capture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_capture_pkg.sv
// rtl/ad_capture_pkg.sv - shared types and trigger compare for the capture stage
package ad_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_FILL,
    ST_WAIT_TRIG,
    ST_POST_FILL,
    ST_DONE
  } state_t;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

  // Operands arrive sign-extended to 32 bits so one helper serves any DATA_W.
  function automatic logic edge_hit(input logic signed [31:0] prev,
                                    input logic signed [31:0] cur,
                                    input logic signed [31:0] level,
                                    input logic               trig_edge);
    if (trig_edge == TRIG_FALLING) begin
      return (prev > level) && (cur <= level);
    end
    return (prev < level) && (cur >= level);
  endfunction

endpackage

// File: rtl/ad_capture_ram.sv
// rtl/ad_capture_ram.sv - simple dual-port sample RAM with registered read
module ad_capture_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ad_trigger_capture.sv
// rtl/ad_trigger_capture.sv - level/edge triggered window capture with oldest-first readout
module ad_trigger_capture
  import ad_capture_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 10,
  parameter int PRE_DEPTH = 256
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     arm,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic                     trig_edge,
  input  logic                     force_trig,
  input  logic                     rd_en,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  PRE_CNT  = CNT_W'(PRE_DEPTH);
  localparam logic [CNT_W-1:0]  POST_CNT = CNT_W'(DEPTH - PRE_DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_DEPTH);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]         post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic                     prev_valid_q, prev_valid_d;
  logic                     force_flag_q, force_flag_d;
  logic                     rd_valid_q, busy_q, done_q;
  logic                     wr_en, rd_fire, hit;
  logic [DATA_W-1:0]        ram_rd_data;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    trig_addr_d  = trig_addr_q;
    rd_ptr_d     = rd_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    force_flag_d = force_flag_q;
    wr_en        = 1'b0;
    rd_fire      = 1'b0;
    hit          = 1'b0;

    case (state_q)
      ST_PRE_FILL: begin
        if (sample_valid) begin
          wr_en        = 1'b1;
          wr_ptr_d     = wr_ptr_q + PTR_ONE;
          pre_cnt_d    = pre_cnt_q + CNT_ONE;
          prev_d       = sample_in;
          prev_valid_d = 1'b1;
          if (pre_cnt_d == PRE_CNT) state_d = ST_WAIT_TRIG;
        end
      end
      ST_WAIT_TRIG: begin
        if (force_trig) force_flag_d = 1'b1;
        if (sample_valid) begin
          hit = force_flag_q || force_trig ||
                (prev_valid_q && edge_hit(32'(prev_q), 32'(sample_in),
                                          32'(trig_level), trig_edge));
          wr_en        = 1'b1;
          wr_ptr_d     = wr_ptr_q + PTR_ONE;
          prev_d       = sample_in;
          prev_valid_d = 1'b1;
          if (hit) begin
            trig_addr_d  = wr_ptr_q;
            post_cnt_d   = CNT_ONE;
            force_flag_d = 1'b0;
            state_d      = (POST_CNT == CNT_ONE) ? ST_DONE : ST_POST_FILL;
          end
        end
      end
      ST_POST_FILL: begin
        if (sample_valid) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          post_cnt_d = post_cnt_q + CNT_ONE;
          if (post_cnt_d == POST_CNT) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rd_en && (rd_cnt_q != FULL_CNT)) begin
          rd_fire  = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase

    // Oldest sample of the window sits PRE_DEPTH slots behind the trigger.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      rd_ptr_d = trig_addr_d - PRE_OFS;
      rd_cnt_d = '0;
    end

    if (arm) begin
      state_d      = ST_PRE_FILL;
      wr_ptr_d     = '0;
      pre_cnt_d    = '0;
      post_cnt_d   = '0;
      rd_cnt_d     = '0;
      prev_valid_d = 1'b0;
      force_flag_d = 1'b0;
      wr_en        = 1'b0;
      rd_fire      = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      trig_addr_q  <= '0;
      rd_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_flag_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      trig_addr_q  <= trig_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      force_flag_q <= force_flag_d;
      rd_valid_q   <= rd_fire;
      busy_q       <= (state_d == ST_PRE_FILL) || (state_d == ST_WAIT_TRIG) ||
                      (state_d == ST_POST_FILL);
      done_q       <= (state_d == ST_DONE);
    end
  end

  ad_capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_in),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (sample_in),
    .rd_en_i   (rd_fire),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  // RAM output has no reset; qualify it so rd_data reads 0 outside a read pulse.
  assign rd_data  = rd_valid_q ? $signed(ram_rd_data) : '0;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ad_trigger_capture.sv
// tb/tb_ad_trigger_capture.sv - self-checking bench for ad_trigger_capture
module tb_ad_trigger_capture;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int PRE    = 4;
  localparam int POST   = DEPTH - PRE;

  logic                     clk_in = 1'b0;
  logic                     rst_n;
  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic                     arm;
  logic signed [DATA_W-1:0] trig_level;
  logic                     trig_edge;
  logic                     force_trig;
  logic                     rd_en;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     busy;
  logic                     done;

  always #5 clk_in = ~clk_in;

  ad_trigger_capture #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .PRE_DEPTH (PRE)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .force_trig   (force_trig),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .done         (done)
  );

  int ncomp = 0;
  int nfail = 0;
  int hist[$];
  int fq[$];
  bit armed = 0;
  bit mdone = 0;
  int lvl   = 0;
  bit edg   = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Index of the first sample after pre-fill that meets the trigger rule, or -1.
  function automatic int trig_idx();
    for (int i = PRE; i < hist.size(); i++) begin
      if (!edg && hist[i-1] < lvl && hist[i] >= lvl) return i;
      if (edg && hist[i-1] > lvl && hist[i] <= lvl) return i;
      foreach (fq[j]) if (fq[j] >= PRE && fq[j] <= i) return i;
    end
    return -1;
  endfunction

  function automatic bit model_done();
    int t;
    t = trig_idx();
    return (t >= 0) && (hist.size() >= t + POST);
  endfunction

  task automatic step(input bit v, input int d, input bit f, input bit r);
    logic [31:0] dv;
    dv           = d;
    sample_valid = v;
    sample_in    = dv[DATA_W-1:0];
    force_trig   = f;
    rd_en        = r;
    @(posedge clk_in);
    if (armed && !mdone) begin
      if (f) fq.push_back(hist.size());
      if (v) hist.push_back(d);
      mdone = model_done();
    end
    #1;
    sample_valid = 1'b0;
    force_trig   = 1'b0;
    rd_en        = 1'b0;
    check("busy", busy, armed && !mdone);
    check("done", done, armed && mdone);
    check("rd_valid_not_done", rd_valid, 0);
  endtask

  task automatic do_arm();
    arm          = 1'b1;
    sample_valid = 1'b0;
    trig_level   = lvl[DATA_W-1:0];
    trig_edge    = edg;
    @(posedge clk_in);
    hist.delete();
    fq.delete();
    armed = 1;
    mdone = 0;
    #1;
    arm = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_done", done, 0);
  endtask

  task automatic fill_random(input int budget);
    int n;
    bit v;
    n = 0;
    while (!mdone && n < budget) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, int'($urandom_range(0, 200)) - 100, !v && (n >= 40), 1'b0);
      n++;
    end
    check("capture_timeout", mdone, 1);
  endtask

  task automatic readout(output int first_val);
    int t, k, c;
    bit r;
    t = trig_idx();
    k = 0;
    c = 0;
    first_val = 0;
    while (k < DEPTH && c < 100) begin
      r     = (c < 2) || ($urandom_range(0, 4) != 0);
      rd_en = r;
      @(posedge clk_in);
      #1;
      rd_en = 1'b0;
      check("rd_valid", rd_valid, r);
      if (rd_valid === 1'b1) begin
        check("rd_data", rd_data, hist[t-PRE+k]);
        if (k == 0) first_val = 32'(rd_data);
        k++;
      end
      c++;
    end
    check("rd_count", k, DEPTH);
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      @(posedge clk_in);
      #1;
      rd_en = 1'b0;
      check("rd_after_window", rd_valid, 0);
    end
    check("done_hold", done, 1);
  endtask

  initial begin
    int fv;
    int v;
    rst_n        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    arm          = 1'b0;
    trig_level   = '0;
    trig_edge    = 1'b0;
    force_trig   = 1'b0;
    rd_en        = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    step(1'b0, 0, 1'b0, 1'b1);

    // Rising ramp through zero
    lvl = 0; edg = 0;
    do_arm();
    v = -20;
    while (!mdone && v < 100) begin
      step(1'b1, v, 1'b0, 1'b0);
      v++;
    end
    check("ramp_done", mdone, 1);
    readout(fv);
    check("ramp_first", fv, -4);

    // Falling through 100
    lvl = 100; edg = 1;
    do_arm();
    step(1'b1, 120, 1'b0, 1'b0);
    step(1'b1, 118, 1'b0, 1'b0);
    step(1'b1, 115, 1'b0, 1'b0);
    step(1'b1, 112, 1'b0, 1'b0);
    step(1'b1, 110, 1'b0, 1'b0);
    step(1'b1, 105, 1'b0, 1'b0);
    step(1'b1, 99, 1'b0, 1'b0);
    fill_random(300);
    readout(fv);
    check("fall_first", fv, 115);

    // Forced trigger on flat input with 3-cycle valid gaps
    lvl = 0; edg = 0;
    do_arm();
    for (int i = 0; i < 60 && !mdone; i++) begin
      step(1'b1, 5, 1'b0, 1'b0);
      step(1'b0, 0, (i == 5), 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
    end
    check("force_done", mdone, 1);
    readout(fv);
    check("force_first", fv, 5);

    // Force during pre-fill must be ignored
    do_arm();
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 5, 1'b0, 1'b0);
    check("prefill_force_busy", busy, 1);
    step(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && !mdone; i++) step(1'b1, 5, 1'b0, 1'b0);
    check("late_force_done", mdone, 1);
    readout(fv);

    // Abort mid post-fill, then require a fresh trigger
    do_arm();
    v = -10;
    while (trig_idx() < 0 || hist.size() < trig_idx() + 3) begin
      step(1'b1, v, 1'b0, 1'b1);
      v++;
    end
    do_arm();
    for (int i = 0; i < 20; i++) step(1'b1, -50, 1'b0, 1'b1);
    v = -50;
    while (!mdone && v < 100) begin
      step(1'b1, v, 1'b0, 1'b0);
      v += 7;
    end
    check("abort_done", mdone, 1);
    readout(fv);

    // Randomised captures
    for (int r = 0; r < 5; r++) begin
      lvl = int'($urandom_range(0, 60)) - 30;
      edg = $urandom_range(0, 1);
      do_arm();
      fill_random(400);
      readout(fv);
    end

    // Asynchronous reset in the middle of a readout
    lvl = 0; edg = 0;
    do_arm();
    fill_random(400);
    rd_en = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    check("pre_reset_rd_valid", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rd_valid", rd_valid, 0);
    check("async_rd_data", rd_data, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    rd_en = 1'b0;
    armed = 0;
    mdone = 0;
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step(1'b1, 3, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
